// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - LCD init/page sequencer driving the ROM address and data_ready strobe
// Each word is acknowledged by a busy rise then fall from the lcd driver, with bounded re-pulses.
module lcd_sequencer #(
  parameter int POWERUP_WAIT = 1000000,
  parameter int INIT_LEN     = 4,
  parameter int CLR_ADDR     = 1,
  parameter int PAGE_LEN     = 32,
  parameter int PAGE0_BASE   = 4,
  parameter int PAGE1_BASE   = 36,
  parameter int ACK_TIMEOUT  = 255,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clock,
  input  logic       internal_reset,
  input  logic       page_sel,
  input  logic       refresh,
  input  logic       lcd_busy,
  output logic [5:0] rom_address,
  output logic       data_ready,
  output logic       seq_busy,
  output logic       lcd_error
);
  localparam int PW_W = $clog2(POWERUP_WAIT + 1);
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam int RT_W = $clog2(MAX_RETRY + 1);
  localparam logic [PW_W-1:0] PW_LAST   = PW_W'(POWERUP_WAIT - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [RT_W-1:0] RT_MAX    = RT_W'(MAX_RETRY);
  localparam logic [5:0]      INIT_LAST = 6'(INIT_LEN - 1);
  localparam logic [5:0]      CLR       = 6'(CLR_ADDR);
  localparam logic [5:0]      BASE0     = 6'(PAGE0_BASE);
  localparam logic [5:0]      BASE1     = 6'(PAGE1_BASE);
  localparam logic [5:0]      LAST0     = 6'(PAGE0_BASE + PAGE_LEN - 1);
  localparam logic [5:0]      LAST1     = 6'(PAGE1_BASE + PAGE_LEN - 1);

  typedef enum logic [2:0] {
    S_POWERUP, S_ISSUE, S_ACK_HI, S_ACK_LO, S_NEXT, S_IDLE, S_PREP
  } state_t;
  typedef enum logic [1:0] {PH_INIT, PH_REDRAW, PH_PAGE} phase_t;

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [5:0]      addr_q, addr_d;
  logic [PW_W-1:0] pw_cnt_q, pw_cnt_d;
  logic [TO_W-1:0] tmo_q, tmo_d;
  logic [RT_W-1:0] retry_q, retry_d, retry_inc;
  logic            pending_q, pending_d;
  logic            page_q, page_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      page_sync_q, ref_sync_q;
  logic            ref_prev_q;
  logic            page_now, ref_edge, go_next;
  logic [5:0]      adv_addr;
  phase_t          adv_phase;
  logic            adv_page, adv_done;

  assign page_now = page_sync_q[1];
  assign ref_edge = ref_sync_q[1] & ~ref_prev_q;

  always_ff @(posedge clock or negedge internal_reset) begin
    if (!internal_reset) begin
      state_q     <= S_POWERUP;
      phase_q     <= PH_INIT;
      addr_q      <= '0;
      pw_cnt_q    <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      pending_q   <= 1'b0;
      page_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      page_sync_q <= '0;
      ref_sync_q  <= '0;
      ref_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      addr_q      <= addr_d;
      pw_cnt_q    <= pw_cnt_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      pending_q   <= pending_d;
      page_q      <= page_d;
      done_q      <= done_d;
      err_q       <= err_d;
      page_sync_q <= {page_sync_q[0], page_sel};
      ref_sync_q  <= {ref_sync_q[0], refresh};
      ref_prev_q  <= ref_sync_q[1];
    end
  end

  // Address that follows the current word; the page is latched when the page phase starts.
  always_comb begin
    adv_addr  = addr_q + 6'd1;
    adv_phase = phase_q;
    adv_page  = page_q;
    adv_done  = 1'b0;
    if (phase_q == PH_REDRAW || (phase_q == PH_INIT && addr_q == INIT_LAST)) begin
      adv_phase = PH_PAGE;
      adv_page  = page_now;
      adv_addr  = page_now ? BASE1 : BASE0;
    end else if (phase_q == PH_PAGE && addr_q == (page_q ? LAST1 : LAST0)) begin
      adv_addr = addr_q;
      adv_done = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    addr_d    = addr_q;
    pw_cnt_d  = pw_cnt_q;
    tmo_d     = tmo_q;
    retry_d   = retry_q;
    pending_d = pending_q | ref_edge;
    page_d    = page_q;
    done_d    = done_q;
    err_d     = err_q;
    retry_inc = retry_q + 1'b1;
    go_next   = 1'b0;
    case (state_q)
      S_POWERUP: begin
        if (pw_cnt_q == PW_LAST) begin
          state_d = S_ISSUE;
          phase_d = PH_INIT;
        end else begin
          pw_cnt_d = pw_cnt_q + 1'b1;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_ACK_HI;
      end
      S_ACK_HI: begin
        if (lcd_busy) begin
          state_d = S_ACK_LO;
        end else if (tmo_q == TO_LAST) begin
          if (retry_inc < RT_MAX) begin
            retry_d = retry_inc;
            state_d = S_ISSUE;
          end else begin
            err_d   = 1'b1;
            go_next = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_ACK_LO: go_next = ~lcd_busy;
      S_NEXT: begin
        retry_d = '0;
        state_d = done_q ? S_IDLE : S_ISSUE;
      end
      S_IDLE: begin
        if (pending_q | ref_edge | (page_now != page_q)) begin
          state_d   = S_PREP;
          phase_d   = PH_REDRAW;
          addr_d    = CLR;
          pending_d = 1'b0;
        end
      end
      S_PREP:  state_d = S_ISSUE;
      default: state_d = S_POWERUP;
    endcase
    // Address moves on entry to NEXT so it is stable for the whole cycle before the next strobe.
    if (go_next) begin
      state_d = S_NEXT;
      addr_d  = adv_addr;
      phase_d = adv_phase;
      page_d  = adv_page;
      done_d  = adv_done;
    end
  end

  assign rom_address = addr_q;
  assign data_ready  = (state_q == S_ISSUE);
  assign seq_busy    = (state_q != S_IDLE);
  assign lcd_error   = err_q;
endmodule

// File: tb/tb_lcd_sequencer.sv
// tb/tb_lcd_sequencer.sv - table-driven and directed bench for lcd_sequencer with an lcd busy model
module tb_lcd_sequencer;
  logic       clock = 1'b0;
  logic       internal_reset = 1'b1;
  logic       page_sel = 1'b0;
  logic       refresh = 1'b0;
  logic       lcd_busy = 1'b0;
  logic [5:0] rom_address;
  logic       data_ready, seq_busy, lcd_error;
  logic       ign5 = 1'b0;
  int         errors = 0, checks = 0, cyc = 0;
  logic [5:0] sq[$];
  int         st[$];

  typedef struct {
    logic             page;
    logic             refr;
    logic             ign;
    int               n;
    logic [15:0][5:0] addrs;
    logic             err;
  } vec_t;
  vec_t vt[5];

  always #5 clock = ~clock;

  lcd_sequencer #(
    .POWERUP_WAIT(8), .INIT_LEN(4), .CLR_ADDR(1), .PAGE_LEN(4),
    .PAGE0_BASE(4), .PAGE1_BASE(8), .ACK_TIMEOUT(6), .MAX_RETRY(2)
  ) dut (
    .clock(clock), .internal_reset(internal_reset), .page_sel(page_sel),
    .refresh(refresh), .lcd_busy(lcd_busy), .rom_address(rom_address),
    .data_ready(data_ready), .seq_busy(seq_busy), .lcd_error(lcd_error)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  function automatic logic [15:0][5:0] lst(input int a0, a1, a2, a3, a4, a5);
    logic [15:0][5:0] r;
    r = '0;
    r[0] = 6'(a0); r[1] = 6'(a1); r[2] = 6'(a2);
    r[3] = 6'(a3); r[4] = 6'(a4); r[5] = 6'(a5);
    return r;
  endfunction

  function automatic logic [15:0][5:0] rng(input int first, input int n);
    logic [15:0][5:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = 6'(first + i);
    return r;
  endfunction

  // lcd model: busy rises 2 cycles after a strobe and stays high 5 cycles
  int bdly = 0, bhi = 0;
  always @(posedge clock) begin
    #1;
    if (!internal_reset) begin
      lcd_busy = 1'b0; bdly = 0; bhi = 0;
    end else begin
      if (bhi > 0) begin
        bhi--;
        if (bhi == 0) lcd_busy = 1'b0;
      end
      if (bdly > 0) begin
        bdly--;
        if (bdly == 0) begin lcd_busy = 1'b1; bhi = 5; end
      end
      if (data_ready && !(ign5 && rom_address == 6'd5)) bdly = 2;
    end
  end

  // strobe monitor: records strobes and checks width, address stability and ack spacing
  logic       prev_dr = 1'b0, hold = 1'b0, hold_bad = 1'b0, seen_hi = 1'b0, acked = 1'b1;
  logic [5:0] prev_addr = '0, hold_addr = '0;
  int         last_strobe = -100;
  always @(negedge clock) begin
    cyc++;
    if (!internal_reset) begin
      prev_dr = 1'b0; hold = 1'b0; acked = 1'b1; last_strobe = -100;
      prev_addr = rom_address;
    end else begin
      if (hold) begin
        if (rom_address != hold_addr) hold_bad = 1'b1;
        if (lcd_busy) seen_hi = 1'b1;
        else if (seen_hi) begin
          check("addr_hold_until_ack", int'(hold_bad), 0);
          hold = 1'b0; acked = 1'b1;
        end
      end
      if (data_ready) begin
        sq.push_back(rom_address);
        st.push_back(cyc);
        check("strobe_rules", int'({prev_dr, rom_address != prev_addr,
                                     !(acked || (cyc - last_strobe) >= 7)}), 0);
        hold = 1'b1; hold_addr = rom_address; hold_bad = 1'b0; seen_hi = 1'b0;
        acked = 1'b0; last_strobe = cyc;
      end
      prev_dr = data_ready;
      prev_addr = rom_address;
    end
  end

  task automatic release_and_powerup(input string name);
    internal_reset = 1'b1;
    sq.delete(); st.delete();
    repeat (7) tick();
    check({name, "_powerup_quiet"}, sq.size(), 0);
    tick();
    check({name, "_first_strobe"}, int'({data_ready, rom_address}), int'({1'b1, 6'd0}));
  endtask

  task automatic run_quiet(input int budget, output logic saw_busy, output logic ok);
    int q;
    q = 0; saw_busy = 1'b0; ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (seq_busy) begin saw_busy = 1'b1; q = 0; end
      else q++;
      if (q >= 20) begin ok = 1'b1; break; end
    end
  endtask

  task automatic cmp_list(input string name, input logic [15:0][5:0] exp, input int n);
    check({name, "_count"}, sq.size(), n);
    for (int i = 0; i < n && i < sq.size(); i++)
      check($sformatf("%s_addr%0d", name, i), int'(sq[i]), int'(exp[i]));
  endtask

  initial begin
    logic sb, ok;
    logic [15:0][5:0] e;
    int found;
    vt[0] = '{1'b1, 1'b0, 1'b0, 5, lst(1, 8, 9, 10, 11, 0), 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b0, 5, lst(1, 8, 9, 10, 11, 0), 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 5, lst(1, 4, 5, 6, 7, 0), 1'b0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 6, lst(1, 4, 5, 5, 6, 7), 1'b1};
    vt[4] = '{1'b1, 1'b0, 1'b0, 5, lst(1, 8, 9, 10, 11, 0), 1'b1};

    // reset state and power-up/init/page0 draw
    tick();
    internal_reset = 1'b0;
    repeat (2) tick();
    check("reset_addr", int'(rom_address), 0);
    check("reset_data_ready", int'(data_ready), 0);
    check("reset_seq_busy", int'(seq_busy), 1);
    check("reset_lcd_error", int'(lcd_error), 0);
    release_and_powerup("t1");
    run_quiet(400, sb, ok);
    check("t1_settle", int'(ok), 1);
    cmp_list("t1", rng(0, 8), 8);
    check("t1_lcd_error", int'(lcd_error), 0);

    // redraw vectors applied from IDLE
    for (int v = 0; v < 5; v++) begin
      sq.delete(); st.delete();
      page_sel = vt[v].page;
      refresh = vt[v].refr;
      ign5 = vt[v].ign;
      repeat (3) tick();
      refresh = 1'b0;
      run_quiet(400, sb, ok);
      ign5 = 1'b0;
      check($sformatf("v%0d_settle", v), int'(ok), 1);
      check($sformatf("v%0d_seq_busy_seen", v), int'(sb), 1);
      check($sformatf("v%0d_seq_busy_end", v), int'(seq_busy), 0);
      cmp_list($sformatf("v%0d", v), vt[v].addrs, vt[v].n);
      check($sformatf("v%0d_lcd_error", v), int'(lcd_error), int'(vt[v].err));
      if (vt[v].ign && st.size() >= 4)
        check($sformatf("v%0d_retry_gap", v), st[3] - st[2], 7);
    end

    // triggers during init coalesce into one redraw after the page0 draw
    internal_reset = 1'b0;
    page_sel = 1'b0;
    repeat (2) tick();
    release_and_powerup("t3");
    refresh = 1'b1; repeat (3) tick();
    refresh = 1'b0; page_sel = 1'b1; repeat (3) tick();
    refresh = 1'b1; page_sel = 1'b0; repeat (3) tick();
    refresh = 1'b0;
    run_quiet(600, sb, ok);
    check("t3_settle", int'(ok), 1);
    e = rng(0, 8);
    e[8] = 6'd1; e[9] = 6'd4; e[10] = 6'd5; e[11] = 6'd6; e[12] = 6'd7;
    cmp_list("t3", e, 13);
    check("t3_lcd_error", int'(lcd_error), 0);

    // reset while waiting for busy to fall at address 2
    internal_reset = 1'b0;
    repeat (2) tick();
    release_and_powerup("t5a");
    found = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rom_address == 6'd2 && lcd_busy) begin found = 1; break; end
    end
    check("t5_reach_ack_lo", found, 1);
    tick();
    internal_reset = 1'b0;
    #1;
    check("t5_reset_addr", int'(rom_address), 0);
    check("t5_reset_data_ready", int'(data_ready), 0);
    check("t5_reset_seq_busy", int'(seq_busy), 1);
    check("t5_reset_lcd_error", int'(lcd_error), 0);
    repeat (2) tick();
    release_and_powerup("t5b");
    run_quiet(400, sb, ok);
    check("t5_settle", int'(ok), 1);
    cmp_list("t5", rng(0, 8), 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
